ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Round-robin arbiter that shares one downstream resource among `N` requesters, using a one-hot ring pointer as its priority rotator. The requester just after the previous winner has highest priority, so no requester starves. The block sits between the requester ports and the shared resource's enable/select lines, and exposes the grant both as one-hot and as an encoded index.

## Interface
- `N`, 4: number of requesters, 2..16.
- `MAX_HOLD`, 8: maximum consecutive grant cycles before forced handover. Used only when `RR_ARB_TIMEOUT_EN` is defined. Must be ≥ 2.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset (sampled on the `clk` rising edge).
- `req` input, N: request per requester; held high for the whole transaction, dropped to release.
- `gnt` output, N: registered one-hot grant; all-zero when idle.
- `gnt_valid` output, 1: high whenever `gnt` is non-zero.
- `gnt_id` output, $clog2(N): binary index of the granted requester; 0 when idle.
- `ptr` output, N: current one-hot ring pointer (highest-priority position).
- `preempt` output, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values:
  - `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `preempt` = 0.
  - `ptr` = one-hot with bit 0 set (`N'b0…01`).
  - State = IDLE, hold counter = 0.
- States are IDLE and BUSY.
- **IDLE:**
  - If `req` ≠ 0, pick the winner: the first set `req` bit found scanning upward from the set bit of `ptr`, wrapping from N-1 to 0.
  - Next edge: `gnt` = winner, state → BUSY, `ptr` → winner rotated left by one (bit (w+1) mod N), hold counter → 0.
- **BUSY, owner's `req` still high:** grant is held. The hold counter increments and saturates at MAX_HOLD-1.
- **BUSY, owner's `req` low:**
  - If other requests are pending, hand over on the same edge: `gnt` moves directly to the next winner from `ptr`, with no idle cycle. `ptr` rotates and the counter clears.
  - Otherwise `gnt` → 0 and state → IDLE. `ptr` is unchanged.
- The owner is never re-granted in the handover cycle, even if its `req` rises again. It is already lowest priority because `ptr` points past it.
- Requests arriving mid-grant are ignored until a handover decision.
- `gnt` is always one-hot or zero. A zero-to-nonzero transition happens only from IDLE.
- `rst` in any state overrides everything and returns all outputs to reset values on that edge. In-flight ownership is lost.

## Timing
- Grant latency: `req` sampled high at edge k, `gnt` high after edge k (visible in cycle k+1). Latency is 1 cycle.
- Release latency: owner's `req` low at edge k → `gnt` changes after edge k.
- `gnt_id`, `gnt_valid` and `ptr` are registered together with `gnt`; they are never combinational from `req`.
- `preempt` is high for exactly the cycle in which the new `gnt` first appears after a timeout.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- **Defined:** when the hold counter equals MAX_HOLD-1 and any other `req` bit is high, the next edge forces a handover exactly like a release, and pulses `preempt`. If no one else requests, the owner keeps the grant and the counter stays saturated.
- **Undefined:** no hold counter is built. A grant lasts until the owner releases, `preempt` is tied to 0, and `MAX_HOLD` is ignored.

## Structure
- Package `ring_arb_pkg`:
  - State enum `arb_state_t` {IDLE, BUSY}.
  - Default constants `ARB_N_DEF` = 4 and `ARB_MAX_HOLD_DEF` = 8.
  - Function `onehot_to_idx` for `gnt_id` encoding.
  - Function `rr_pick(req, ptr)` returning a one-hot winner.
- Sub-module `ring_pointer`: N-bit one-hot rotate register with load.
  - Reset value 1.
  - Inputs `load` and `next` (one-hot).
  - On load: value ← `next` rotated left by one.
- Top level holds the FSM, the hold counter and the output registers.

## Test plan
- **Reset:** hold `rst` 2 cycles with `req` = 4'b1111 → `gnt` = 0, `ptr` = 4'b0001, `gnt_id` = 0, `preempt` = 0 throughout the reset cycles.
- **Single request:** `req` = 4'b0100 from IDLE → `gnt` = 4'b0100 and `gnt_id` = 2 one cycle later, `ptr` = 4'b1000. Drop `req` → `gnt` = 0 next cycle.
- **Fairness:**
  - Initial grant: `req` = 4'b1111, each owner releasing after 3 cycles → grants go 0, 1, 2, 3, 0 with no idle cycles between.
  - Wrap-around handover: owner 3 releases → `gnt` goes from 4'b1000 to 4'b0001 in one edge.
- **Priority wrap:** `ptr` = 4'b1000, `req` = 4'b0011 → grant to 0, `ptr` → 4'b0010.
- **Timeout (macro defined, MAX_HOLD = 8):** req0 held forever, req1 raised at cycle 2 → `gnt` moves to 4'b0010 after grant cycle 8, with `preempt` = 1 for one cycle. With req0 alone, the grant is held indefinitely.
- **Mid-grant reset:** assert `rst` while `gnt` = 4'b0010 → next cycle all outputs are at reset values. After `rst` drops, with `req` = 4'b0010 still high → re-granted one cycle later.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared types, default sizes and pick/encode helpers for the ring round-robin arbiter.
// Helpers work on a 16-bit maximum width; callers zero-extend and truncate with size casts.
package ring_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;
    localparam int ARB_N_MAX        = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [ARB_N_MAX-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_N_MAX; i++)
            if (oh[i]) idx |= 4'(i);
        return idx;
    endfunction

    // Lowest set request at or above the pointer bit, else wrap to lowest set request overall.
    function automatic logic [ARB_N_MAX-1:0] rr_pick(input logic [ARB_N_MAX-1:0] req,
                                                     input logic [ARB_N_MAX-1:0] ptr);
        logic [ARB_N_MAX-1:0] hi, src;
        hi  = req & ~(ptr - 16'd1);
        src = (hi != '0) ? hi : req;
        return src & (~src + 16'd1);
    endfunction

endpackage

// File: rtl/ring_pointer.sv
// One-hot priority pointer; on load it moves one position past the supplied winner.
module ring_pointer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] next,
    output logic [N-1:0] ptr
);

    logic [N-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst)       ptr_q <= N'(1);
        else if (load) ptr_q <= {next[N-2:0], next[N-1]};
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with registered one-hot/encoded grant and ring priority pointer.
// Define RR_ARB_TIMEOUT_EN to add the hold counter that forces handover after MAX_HOLD cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [N-1:0]         ptr,
    output logic                 preempt
);

    localparam int IDW = $clog2(N);

    if (N < 2 || N > ARB_N_MAX) begin : g_bad_n
        $error("ring_rr_arbiter: N out of range");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("ring_rr_arbiter: MAX_HOLD must be >= 2");
    end

    arb_state_t     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d, others, win;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_valid_q;
    logic           load, owner_hold, timeout;

    always_comb begin
        // The current owner is masked out so it can never win its own handover.
        others     = req & ~gnt_q;
        win        = N'(rr_pick(16'(others), 16'(ptr)));
        owner_hold = |(req & gnt_q);
        state_d    = state_q;
        gnt_d      = gnt_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = win;
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!owner_hold || timeout) begin
                    if (|others) begin
                        gnt_d = win;
                        load  = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        gnt_id_d = IDW'(onehot_to_idx(16'(gnt_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          preempt_q, preempt_d;

    always_comb begin
        timeout   = (cnt_q == CW'(MAX_HOLD - 1)) && (|others);
        // Only a revoke from a still-requesting owner counts as a preemption.
        preempt_d = (state_q == BUSY) && owner_hold && timeout;
        cnt_d     = cnt_q;
        if (load)
            cnt_d = '0;
        else if (state_q == BUSY && cnt_q != CW'(MAX_HOLD - 1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif

    ring_pointer #(.N(N)) u_ptr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .next (gnt_d),
        .ptr  (ptr)
    );

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4); timeout checks run when RR_ARB_TIMEOUT_EN is defined.
module tb_ring_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic [N-1:0] ptr;
    logic         preempt;

    int n_chk = 0;
    int n_err = 0;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .ptr       (ptr),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic [3:0] p, input logic pe);
        chk({tag, ".gnt"},   32'(gnt), 32'(g));
        chk({tag, ".id"},    32'(gnt_id), 32'(id));
        chk({tag, ".vld"},   32'(gnt_valid), 32'(g != 4'b0));
        chk({tag, ".ptr"},   32'(ptr), 32'(p));
        chk({tag, ".pre"},   32'(preempt), 32'(pe));
    endtask

    initial begin
        logic [3:0] own;
        rst = 1'b1;
        req = 4'b1111;
        #1;
        step();
        chk_all("rst0", 4'b0000, 2'd0, 4'b0001, 1'b0);
        step();
        chk_all("rst1", 4'b0000, 2'd0, 4'b0001, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        step();
        chk_all("idle", 4'b0000, 2'd0, 4'b0001, 1'b0);

        // Single request and release
        req = 4'b0100;
        step();
        chk_all("single", 4'b0100, 2'd2, 4'b1000, 1'b0);
        req = 4'b0000;
        step();
        chk_all("single_rel", 4'b0000, 2'd0, 4'b1000, 1'b0);

        // Priority wrap from ptr=1000
        req = 4'b0011;
        step();
        chk_all("wrap", 4'b0001, 2'd0, 4'b0010, 1'b0);
        req = 4'b0000;
        step();
        chk_all("wrap_rel", 4'b0000, 2'd0, 4'b0010, 1'b0);

        // Fairness: all request, each owner releases after 3 grant cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            own = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("fair%0d_%0d.gnt", k, c), 32'(gnt), 32'(own));
                chk($sformatf("fair%0d_%0d.id", k, c), 32'(gnt_id), k % 4);
                if (c < 2) step();
            end
            req = 4'b1111 & ~own;
            step();
            req = 4'b1111;
        end
        chk_all("fair_end", 4'b0010, 2'd1, 4'b0100, 1'b0);

        // Mid-grant reset, then re-grant with req still high
        rst = 1'b1;
        req = 4'b0010;
        step();
        chk_all("midrst", 4'b0000, 2'd0, 4'b0001, 1'b0);
        rst = 1'b0;
        step();
        chk_all("regrant", 4'b0010, 2'd1, 4'b0100, 1'b0);
        req = 4'b0000;
        step();
        chk_all("regrant_rel", 4'b0000, 2'd0, 4'b0100, 1'b0);

        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        req = 4'b0001;
        step();
        chk_all("to_g1", 4'b0001, 2'd0, 4'b0010, 1'b0);
        req = 4'b0011;
        for (int c = 2; c <= 8; c++) begin
            step();
            chk($sformatf("to_g%0d.gnt", c), 32'(gnt), 32'h1);
            chk($sformatf("to_g%0d.pre", c), 32'(preempt), 32'h0);
        end
        step();
        chk_all("to_hand", 4'b0010, 2'd1, 4'b0100, 1'b1);
        step();
        chk_all("to_after", 4'b0010, 2'd1, 4'b0100, 1'b0);
        req = 4'b0001;
        step();
        chk_all("to_back", 4'b0001, 2'd0, 4'b0010, 1'b0);
        for (int c = 0; c < 20; c++) step();
        chk_all("to_alone", 4'b0001, 2'd0, 4'b0010, 1'b0);
`else
        req = 4'b0001;
        step();
        chk_all("hold_g1", 4'b0001, 2'd0, 4'b0010, 1'b0);
        req = 4'b0011;
        for (int c = 0; c < 12; c++) step();
        chk_all("hold_long", 4'b0001, 2'd0, 4'b0010, 1'b0);
        req = 4'b0010;
        step();
        chk_all("hold_rel", 4'b0010, 2'd1, 4'b0100, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
